// File: rtl/flow_arbiter_pkg.sv
// Shared constants and types for the VC flow arbiter.
package flow_pkg;
  localparam int NUM_VC       = 4;
  localparam int VC_W         = 2;
  localparam int DATA_W_DEF   = 6;
  localparam int WEIGHT_W_DEF = 4;

  typedef logic [VC_W-1:0] vc_id_t;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'b001,
    ARB_RUN    = 3'b010,
    ARB_FREEZE = 3'b100
  } arb_state_e;
endpackage

// File: rtl/flow_arbiter_if.sv
// Upstream VC FIFO read side plus downstream FIFO write side.
// master = arbiter, slave = FIFO side.
interface flow_arb_if #(parameter int DATA_W = 6);
  import flow_pkg::*;
  logic [NUM_VC-1:0]        vc_empty;
  logic [NUM_VC*DATA_W-1:0] vc_dout;
  logic [NUM_VC-1:0]        vc_pop;
  logic                     out_afull;
  logic                     out_push;
  logic [DATA_W+1:0]        out_data;

  modport master (input vc_empty, vc_dout, out_afull, output vc_pop, out_push, out_data);
  modport slave  (output vc_empty, vc_dout, out_afull, input vc_pop, out_push, out_data);
endinterface

// File: rtl/flow_arbiter_rr_next_vc.sv
// Rotating search: first eligible VC strictly after cur_vc, wrapping back
// to cur_vc itself as the last candidate.
module rr_next_vc
  import flow_pkg::*;
(
  input  vc_id_t            cur_vc,
  input  logic [NUM_VC-1:0] elig,
  output vc_id_t            nxt_vc,
  output logic              found
);
  vc_id_t cand;

  // Scan farthest-first so the nearest eligible VC wins the last write
  always_comb begin
    nxt_vc = cur_vc;
    found  = 1'b0;
    cand   = cur_vc;
    for (int k = NUM_VC; k >= 1; k--) begin
      cand = cur_vc + vc_id_t'(k);
      if (elig[cand]) begin
        nxt_vc = cand;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/flow_arbiter.sv
// Weighted round-robin arbiter: 4 VC FIFOs -> one downstream FIFO.
// Words are tagged {vc_id, data}; pop-to-push latency is 2 enabled cycles.
// Optional: FLOW_ARB_GRANT_CNT_EN adds per-VC saturating grant counters.
module flow_arbiter
  import flow_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic                       cfg_load,
  input  logic [NUM_VC*WEIGHT_W-1:0] cfg_weights,
  input  logic [NUM_VC-1:0]          pausa,
  input  logic [NUM_VC-1:0]          error_full,
  output logic                       frozen,
  flow_arb_if.master                 bus
`ifdef FLOW_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_VC*16-1:0]       grant_cnt
`endif
);
  localparam logic [NUM_VC-1:0][WEIGHT_W-1:0] WEIGHT_RST = {NUM_VC{WEIGHT_W'(1)}};

  arb_state_e                      state_q, state_d;
  vc_id_t                          cur_vc_q, cur_vc_d, p1_vc_q, p1_vc_d;
  vc_id_t                          rr_base, rr_vc, pop_vc;
  logic                            rr_found, pop_vld, err_any;
  logic [WEIGHT_W-1:0]             credit_q, credit_d;
  logic [NUM_VC-1:0][WEIGHT_W-1:0] weight_q, weight_d, cfg_w;
  logic [NUM_VC-1:0][DATA_W-1:0]   dout_w;
  logic [NUM_VC-1:0]               elig, vc_pop_w;
  // [0]: popped last cycle (data on vc_dout now), [1]: captured, push pending
  logic [1:0]                      vld_pipe_q, vld_pipe_d;
  logic [DATA_W+1:0]               out_data_q, out_data_d;

  assign cfg_w   = cfg_weights;
  assign dout_w  = bus.vc_dout;
  assign err_any = |error_full;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_elig
    assign elig[i] = !bus.vc_empty[i] && !pausa[i] && (weight_q[i] != '0) && !bus.out_afull;
  end

  // IDLE searches from cur_vc inclusive, so start the "after" search one back
  assign rr_base = (state_q == ARB_IDLE) ? cur_vc_q - 1'b1 : cur_vc_q;

  rr_next_vc u_rr (
    .cur_vc (rr_base),
    .elig   (elig),
    .nxt_vc (rr_vc),
    .found  (rr_found)
  );

  // State register: FSM, credit, weight table and capture pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      cur_vc_q   <= '0;
      credit_q   <= '0;
      weight_q   <= WEIGHT_RST;
      vld_pipe_q <= '0;
      p1_vc_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_vc_q   <= cur_vc_d;
      credit_q   <= credit_d;
      weight_q   <= weight_d;
      vld_pipe_q <= vld_pipe_d;
      p1_vc_q    <= p1_vc_d;
      out_data_q <= out_data_d;
    end
  end

  // Next state: error_full beats enb, enb beats config and arbitration.
  // A fresh grant pops immediately, so credit holds weight-1 remaining pops.
  always_comb begin
    state_d    = state_q;
    cur_vc_d   = cur_vc_q;
    credit_d   = credit_q;
    weight_d   = weight_q;
    vld_pipe_d = vld_pipe_q;
    p1_vc_d    = p1_vc_q;
    out_data_d = out_data_q;
    pop_vld    = 1'b0;
    pop_vc     = cur_vc_q;
    if (err_any) begin
      state_d = ARB_FREEZE;
    end else if (enb) begin
      case (state_q)
        ARB_IDLE: begin
          if (rr_found) begin
            state_d  = ARB_RUN;
            pop_vld  = 1'b1;
            pop_vc   = rr_vc;
            cur_vc_d = rr_vc;
            credit_d = weight_q[rr_vc] - 1'b1;
          end
        end
        ARB_RUN: begin
          if (elig[cur_vc_q] && credit_q != '0) begin
            pop_vld  = 1'b1;
            credit_d = credit_q - 1'b1;
          end else if (rr_found) begin
            pop_vld  = 1'b1;
            pop_vc   = rr_vc;
            cur_vc_d = rr_vc;
            credit_d = weight_q[rr_vc] - 1'b1;
          end else begin
            state_d = ARB_IDLE;
          end
        end
        ARB_FREEZE: state_d = ARB_FREEZE;
        default:    state_d = ARB_IDLE;
      endcase
      if (cfg_load) weight_d = cfg_w;
    end
    // Pipeline only moves while enabled; a stalled word waits, it is not lost
    if (enb) begin
      vld_pipe_d = {vld_pipe_q[0], pop_vld};
      p1_vc_d    = pop_vc;
      if (vld_pipe_q[0]) out_data_d = {p1_vc_q, dout_w[p1_vc_q]};
    end
  end

  // Outputs: pop strobe from current decision, push held back while disabled
  always_comb begin
    vc_pop_w = '0;
    if (rst && pop_vld) vc_pop_w[pop_vc] = 1'b1;
    frozen       = (state_q == ARB_FREEZE);
    bus.out_push = vld_pipe_q[1] && enb;
    bus.out_data = out_data_q;
  end

  assign bus.vc_pop = vc_pop_w;

`ifdef FLOW_ARB_GRANT_CNT_EN
  logic [NUM_VC-1:0][15:0] gcnt_q, gcnt_d;

  // Per-VC saturating grant counters
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_VC; i++)
      if (vc_pop_w[i] && gcnt_q[i] != 16'hFFFF) gcnt_d[i] = gcnt_q[i] + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) gcnt_q <= '0;
    else      gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`endif
endmodule

// File: tb/tb_flow_arbiter.sv
// Randomized bench with a queue-based reference model of the arbiter.
module tb_flow_arbiter;
  import flow_pkg::*;
  localparam int DW = 6;
  localparam int WW = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, enb, cfg_load, frozen;
  logic [NUM_VC*WW-1:0]   cfg_weights;
  logic [NUM_VC-1:0]      pausa, error_full;
`ifdef FLOW_ARB_GRANT_CNT_EN
  logic [NUM_VC*16-1:0]   grant_cnt;
`endif

  flow_arb_if #(.DATA_W(DW)) bus ();

  flow_arbiter #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .cfg_load    (cfg_load),
    .cfg_weights (cfg_weights),
    .pausa       (pausa),
    .error_full  (error_full),
    .frozen      (frozen),
    .bus         (bus)
`ifdef FLOW_ARB_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  typedef struct {int age; logic [7:0] w;} fl_t;

  int checks = 0;
  int errors = 0;

  // upstream FIFO contents, read by head index
  logic [DW-1:0] mem [NUM_VC][DEPTH];
  int            head [NUM_VC];
  int            tail [NUM_VC];
  logic [DW-1:0] dout_m [NUM_VC];

  // reference model
  bit         m_frozen, m_active, m_push;
  int         m_vc, m_left;
  int         m_w [NUM_VC];
  logic [7:0] m_data;
  fl_t        infl [$];
  int         m_gcnt [NUM_VC];

  int plog [$];
  int ulog [$];
  int pat2 [7] = '{0, 0, 0, 1, 1, 2, 3};
  int pat3 [5] = '{3, 0, 2, 3, 0};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_frozen = 0; m_active = 0; m_push = 0; m_vc = 0; m_left = 0; m_data = '0;
    infl.delete();
    for (int i = 0; i < NUM_VC; i++) begin
      m_w[i] = 1;
      m_gcnt[i] = 0;
    end
  endtask

  task automatic fill(int n);
    for (int i = 0; i < NUM_VC; i++)
      for (int k = 0; k < n; k++)
        if (tail[i] < DEPTH) begin
          mem[i][tail[i]] = DW'($urandom);
          tail[i]++;
        end
  endtask

  function automatic int count_ge0(int q [$]);
    int n = 0;
    foreach (q[k]) if (q[k] >= 0) n++;
    return n;
  endfunction

  // One cycle: drive FIFO side, compare against model, advance model at posedge
  task automatic tick();
    logic [NUM_VC-1:0] el, ep;
    bit   run, cont;
    int   g, c, ap;
    logic [1:0] vc2;
    fl_t  e;
    for (int i = 0; i < NUM_VC; i++) begin
      bus.vc_empty[i] = (head[i] == tail[i]);
      bus.vc_dout[i*DW +: DW] = dout_m[i];
    end
    #1;
    for (int i = 0; i < NUM_VC; i++)
      el[i] = (head[i] != tail[i]) && !pausa[i] && (m_w[i] != 0) && !bus.out_afull;
    run  = rst && enb && !(|error_full) && !m_frozen;
    cont = m_active && el[m_vc] && (m_left > 0);
    g = -1;
    if (run) begin
      if (cont) g = m_vc;
      else
        for (int j = 0; j < NUM_VC; j++) begin
          c = m_active ? (m_vc + 1 + j) % NUM_VC : (m_vc + j) % NUM_VC;
          if (g < 0 && el[c]) g = c;
        end
    end
    ep = '0;
    if (g >= 0) ep[g] = 1'b1;
    chk("vc_pop", 32'(bus.vc_pop), 32'(ep));
    chk("out_push", 32'(bus.out_push), 32'(m_push && enb));
    if (m_push && enb) chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("frozen", 32'(frozen), 32'(m_frozen));
`ifdef FLOW_ARB_GRANT_CNT_EN
    for (int i = 0; i < NUM_VC; i++) chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
`endif
    ap = -1;
    for (int i = 0; i < NUM_VC; i++) if (bus.vc_pop[i]) ap = i;
    plog.push_back(ap);
    ulog.push_back(bus.out_push ? int'(bus.out_data) : -1);

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (enb) begin
        for (int k = 0; k < infl.size(); k++) infl[k].age++;
        m_push = 0;
        if (infl.size() > 0 && infl[0].age >= 2) begin
          m_push = 1;
          m_data = infl[0].w;
          infl.delete(0);
        end
      end
      if (g >= 0) begin
        dout_m[g] = mem[g][head[g]];
        head[g]++;
        vc2 = 2'(g);
        e.age = 1;
        e.w = {vc2, dout_m[g]};
        infl.push_back(e);
        if (m_gcnt[g] < 65535) m_gcnt[g]++;
      end
      if (run) begin
        if (g < 0) m_active = 0;
        else begin
          if (cont) m_left--;
          else m_left = m_w[g] - 1;
          m_vc = g;
          m_active = 1;
        end
      end
      if (|error_full) m_frozen = 1;
      if (enb && !(|error_full) && cfg_load)
        for (int i = 0; i < NUM_VC; i++) m_w[i] = int'(cfg_weights[i*WW +: WW]);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; cfg_load = 1'b0; cfg_weights = 16'h1111;
    pausa = '0; error_full = '0;
    bus.out_afull = 1'b0; bus.vc_empty = '1; bus.vc_dout = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      head[i] = 0; tail[i] = 0; dout_m[i] = '0;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_vc_pop", 32'(bus.vc_pop), 32'd0);
    chk("rst_out_push", 32'(bus.out_push), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);

    // plain round robin after reset, tags two cycles behind the pops
    fill(24);
    rst = 1'b1;
    plog.delete(); ulog.delete();
    repeat (10) tick();
    for (int k = 0; k < 8; k++) chk("t1_order", plog[k], k % 4);
    chk("t1_lat0", ulog[1], -1);
    chk("t1_first_push", ulog[2], int'(mem[0][0]));
    chk("t1_second_push", ulog[3], 64 + int'(mem[1][0]));

    // weights {1,1,2,3}
    rst = 1'b0; tick(); rst = 1'b1;
    pausa = 4'hF; cfg_load = 1'b1; cfg_weights = 16'h1123;
    tick();
    cfg_load = 1'b0; pausa = '0;
    fill(8);
    plog.delete(); ulog.delete();
    repeat (16) tick();
    for (int k = 0; k < 14; k++) chk("t2_pattern", plog[k], pat2[k % 7]);

    // VC1 paused for 5 cycles
    rst = 1'b0; tick(); rst = 1'b1;
    fill(8);
    repeat (3) tick();
    plog.delete();
    pausa = 4'b0010;
    repeat (5) tick();
    pausa = '0;
    for (int k = 0; k < 5; k++) chk("t3_pausa", plog[k], pat3[k]);

    // downstream almost full: in-flight words drain, nothing new
    fill(8);
    repeat (3) tick();
    bus.out_afull = 1'b1;
    plog.delete(); ulog.delete();
    repeat (6) tick();
    bus.out_afull = 1'b0;
    chk("t4_afull_pushes", count_ge0(ulog), 2);
    chk("t4_afull_pops", count_ge0(plog), 0);

    // enable low for 3 cycles with words in flight
    fill(8);
    repeat (4) tick();
    enb = 1'b0;
    ulog.delete();
    repeat (3) tick();
    chk("t6_stall_pushes", count_ge0(ulog), 0);
    enb = 1'b1;
    ulog.delete();
    repeat (2) tick();
    chk("t6_resume_pushes", count_ge0(ulog), 2);

    // error_full mid-run
    fill(8);
    repeat (4) tick();
    error_full = 4'b0100;
    plog.delete(); ulog.delete();
    tick();
    error_full = '0;
    chk("t5_frozen_next", 32'(frozen), 32'd1);
    repeat (6) tick();
    chk("t5_pushes", count_ge0(ulog), 2);
    chk("t5_pops", count_ge0(plog), 0);
    chk("t5_still_frozen", 32'(frozen), 32'd1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t5_unfrozen", 32'(frozen), 32'd0);

    // random traffic against the model
    repeat (700) begin
      rst           = ($urandom_range(0, 79) != 0);
      enb           = ($urandom_range(0, 9) != 0);
      pausa         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      error_full    = ($urandom_range(0, 249) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      cfg_load      = ($urandom_range(0, 19) == 0);
      cfg_weights   = 16'($urandom);
      bus.out_afull = ($urandom_range(0, 6) == 0);
      for (int i = 0; i < NUM_VC; i++)
        if ($urandom_range(0, 2) == 0 && tail[i] < DEPTH) begin
          mem[i][tail[i]] = DW'($urandom);
          tail[i]++;
        end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
